// File: rtl/turf_surf_cmd_tx.sv
// turf_surf_cmd_tx: serial command transmitter that drives the TURF->SURF
// command lines. A frame is START(1), 32 data bits MSB first, an optional
// odd-parity bit, then an inter-frame gap of zeros. Only lines whose bit is
// set in the latched SURF mask carry the frame; all other lines stay 0.
// Optional feature macro: TURF_CMD_PARITY_EN (adds the PARITY bit period).
//
// Handshake: a command transfers on a rising CLK125 edge where CMD_VALID=1
// and CMD_READY=1. CMD_READY is registered and high only in IDLE; the source
// must hold CMD_DATA/CMD_SURF_MASK stable until that edge. An all-zero mask
// is consumed without sending a frame.
module turf_surf_cmd_tx #(
  parameter int NUM_SURFS = 12,
  parameter int DIV       = 4,
  parameter int GAP_BITS  = 2
) (
  input  logic                 CLK125,
  input  logic                 RST_N,
  input  logic [31:0]          CMD_DATA,
  input  logic [NUM_SURFS-1:0] CMD_SURF_MASK,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  output logic [NUM_SURFS-1:0] CMD,
  output logic                 BUSY,
  output logic [15:0]          FRAME_CNT,
  output logic [2:0]           DBG_STATE
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  logic [2:0]           state;
  logic [7:0]           div_cnt;
  logic [4:0]           bit_idx;
  logic [3:0]           gap_cnt;
  logic [31:0]          data_q;
  logic [NUM_SURFS-1:0] mask_q;
  logic [15:0]          frame_cnt_q;

  logic       bit_end;
  logic [4:0] next_idx;
`ifdef TURF_CMD_PARITY_EN
  logic       parity_bit;
`endif

  assign FRAME_CNT = frame_cnt_q;
  assign DBG_STATE = state;

  // Bit-period boundary, next data index and odd parity of the latched word.
  always_comb begin
    bit_end  = (div_cnt == DIV_LAST);
    next_idx = bit_idx - 5'd1;
`ifdef TURF_CMD_PARITY_EN
    parity_bit = ~^data_q;
`endif
  end

  // Frame sequencer; CMD is loaded with the value of the period being entered
  // so the line changes on the same edge as the state.
  always_ff @(posedge CLK125 or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      frame_cnt_q <= '0;
      CMD         <= '0;
      CMD_READY   <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Zero-mask commands are consumed here and never leave IDLE.
          if (CMD_VALID && CMD_READY && (|CMD_SURF_MASK)) begin
            data_q    <= CMD_DATA;
            mask_q    <= CMD_SURF_MASK;
            div_cnt   <= '0;
            state     <= S_START;
            CMD       <= CMD_SURF_MASK;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_idx <= 5'd31;
            state   <= S_DATA;
            CMD     <= data_q[31] ? mask_q : '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 5'd0) begin
`ifdef TURF_CMD_PARITY_EN
              state <= S_PARITY;
              CMD   <= parity_bit ? mask_q : '0;
`else
              state   <= S_GAP;
              gap_cnt <= '0;
              CMD     <= '0;
`endif
            end else begin
              bit_idx <= next_idx;
              CMD     <= data_q[next_idx] ? mask_q : '0;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
            CMD     <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (gap_cnt == GAP_LAST) begin
              state       <= S_IDLE;
              CMD_READY   <= 1'b1;
              BUSY        <= 1'b0;
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          div_cnt   <= '0;
          CMD       <= '0;
          CMD_READY <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_turf_surf_cmd_tx.sv
// Testbench for turf_surf_cmd_tx. Expected line activity is generated from the
// frame format (start, data MSB first, optional odd parity, gap) expanded into
// a per-cycle queue of expected CMD words.
module tb_turf_surf_cmd_tx;

  localparam int NS   = 12;
  localparam int DIV  = 4;
  localparam int GAPB = 2;
`ifdef TURF_CMD_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   cmd_data;
  logic [NS-1:0] cmd_surf_mask;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NS-1:0] cmd;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  turf_surf_cmd_tx #(.NUM_SURFS(NS), .DIV(DIV), .GAP_BITS(GAPB)) dut (
    .CLK125(clk),
    .RST_N(rst_n),
    .CMD_DATA(cmd_data),
    .CMD_SURF_MASK(cmd_surf_mask),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD(cmd),
    .BUSY(busy),
    .FRAME_CNT(frame_cnt),
    .DBG_STATE(dbg_state)
  );

  // scoreboard
  logic [NS-1:0] exp_q[$];
  logic [15:0]   exp_cnt;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: expand one command into the per-cycle CMD words.
  task automatic build_frame(input logic [31:0] d, input logic [NS-1:0] m);
    bit b_q[$];
    exp_q.delete();
    b_q.push_back(1'b1);
    for (int i = 31; i >= 0; i--) b_q.push_back(d[i]);
    if (PAR_EN) b_q.push_back(($countones(d) % 2) == 0);
    for (int i = 0; i < GAPB; i++) b_q.push_back(1'b0);
    foreach (b_q[i])
      for (int k = 0; k < DIV; k++) exp_q.push_back(b_q[i] ? m : '0);
  endtask

  // Driver + checker for one frame. Entry: at a negedge in IDLE with
  // cmd_valid/cmd_data/cmd_surf_mask already driven for this frame.
  task automatic run_frame(input logic [31:0] d, input logic [NS-1:0] m,
                           input bit hold, input logic [31:0] nd,
                           input logic [NS-1:0] nm, input string tag);
    int busy_cycles;
    logic [NS-1:0] e;
    build_frame(d, m);
    chk({tag, "_ready_pre"}, cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      cmd_data      = nd;
      cmd_surf_mask = nm;
    end else begin
      cmd_valid     = 1'b0;
      cmd_data      = $urandom;
      cmd_surf_mask = NS'($urandom);
    end
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_cmd"}, cmd, e);
      chk({tag, "_ready_lo"}, cmd_ready, 1'b0);
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_busy_len"}, busy_cycles, PAR_EN ? 144 : 140);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_ready"}, cmd_ready, 1'b1);
    chk({tag, "_idle_cmd"}, cmd, '0);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_cnt);
  endtask

  initial begin
    logic [31:0]   d;
    logic [NS-1:0] m;
    rst_n         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_data      = '0;
    cmd_surf_mask = '0;
    exp_cnt       = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cmd", cmd, '0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cnt", frame_cnt, 16'h0000);
    rst_n = 1'b1;

    // directed: alternating pattern on SURF 0 only; accept on first edge after release
    cmd_valid = 1'b1; cmd_data = 32'hA5A5A5A5; cmd_surf_mask = 12'h001;
    run_frame(32'hA5A5A5A5, 12'h001, 1'b0, '0, '0, "a5");

    // directed: last data bit 1 on all lines
    cmd_valid = 1'b1; cmd_data = 32'h00000001; cmd_surf_mask = 12'hFFF;
    run_frame(32'h00000001, 12'hFFF, 1'b0, '0, '0, "one_all");

    // zero mask: consumed, no frame
    cmd_valid = 1'b1; cmd_data = $urandom; cmd_surf_mask = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zm_ready", cmd_ready, 1'b1);
      chk("zm_cmd", cmd, '0);
      chk("zm_busy", busy, 1'b0);
      chk("zm_cnt", frame_cnt, exp_cnt);
    end
    cmd_valid = 1'b0;
    @(negedge clk);

    // back-to-back with valid held; data changes mid-frame to the next word
    d = $urandom; m = NS'($urandom_range(1, 4095));
    cmd_valid = 1'b1; cmd_data = 32'hDEADBEEF; cmd_surf_mask = 12'h5A3;
    run_frame(32'hDEADBEEF, 12'h5A3, 1'b1, d, m, "b2b_first");
    // run_frame returns in the single idle cycle; next edge accepts word two
    run_frame(d, m, 1'b0, '0, '0, "b2b_second");

    // randomized frames
    for (int n = 0; n < 6; n++) begin
      d = $urandom; m = NS'($urandom_range(1, 4095));
      cmd_valid = 1'b1; cmd_data = d; cmd_surf_mask = m;
      run_frame(d, m, 1'b0, '0, '0, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // asynchronous reset during data bit 10
    d = $urandom; m = NS'($urandom_range(1, 4095));
    cmd_valid = 1'b1; cmd_data = d; cmd_surf_mask = m;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (89) @(negedge clk);
    chk("mid_bit10", cmd, d[10] ? m : '0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", cmd, '0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cnt", frame_cnt, 16'h0000);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    d = $urandom; m = NS'($urandom_range(1, 4095));
    cmd_valid = 1'b1; cmd_data = d; cmd_surf_mask = m;
    run_frame(d, m, 1'b0, '0, '0, "post_rst");

    // frame counter wrap
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    d = $urandom; m = NS'($urandom_range(1, 4095));
    cmd_valid = 1'b1; cmd_data = d; cmd_surf_mask = m;
    run_frame(d, m, 1'b0, '0, '0, "wrap");
    chk("wrap_zero", frame_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
